// File: rtl/cache_refill_ctrl_if.sv
// Signal bundle joining the refill controller to the CPU, the tag comparator and memory.
// The controller sits on the slave modport; the surrounding system drives the master side.
interface cache_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] lookup_addr;
    logic                  hit;
    logic [1:0]            hit_index;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] tag_out_0;
    logic [ADDR_WIDTH-1:0] tag_out_1;
    logic [ADDR_WIDTH-1:0] tag_out_2;
    logic [ADDR_WIDTH-1:0] tag_out_3;
    logic                  valid_0;
    logic                  valid_1;
    logic                  valid_2;
    logic                  valid_3;

    modport master (
        output req_valid, req_addr, hit, hit_index, mem_req_ready,
               mem_resp_valid, mem_resp_data, flush,
        input  req_ready, lookup_addr, resp_valid, resp_data, mem_req_valid,
               mem_req_addr, tag_out_0, tag_out_1, tag_out_2, tag_out_3,
               valid_0, valid_1, valid_2, valid_3
    );

    modport slave (
        input  req_valid, req_addr, hit, hit_index, mem_req_ready,
               mem_resp_valid, mem_resp_data, flush,
        output req_ready, lookup_addr, resp_valid, resp_data, mem_req_valid,
               mem_req_addr, tag_out_0, tag_out_1, tag_out_2, tag_out_3,
               valid_0, valid_1, valid_2, valid_3
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Refill controller for a 4-line fully-associative cache: owns tags, valids, data and
// true-LRU ages, serves CPU reads on hit and refills one line from memory on miss.
module cache_refill_ctrl #(
    parameter int CACHE_SIZE = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_refill_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        RESP      = 3'd4
    } state_t;

    // Age 0 is most recently used, age 3 is the eviction candidate.
    typedef logic [CACHE_SIZE-1:0][1:0] ages_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] tag_r  [CACHE_SIZE];
    logic [DATA_WIDTH-1:0] data_r [CACHE_SIZE];
    logic [CACHE_SIZE-1:0] valid_r;
    ages_t                 age_r;
    logic [1:0]            victim_r;
    logic [ADDR_WIDTH-1:0] lookup_addr_r;
    logic [ADDR_WIDTH-1:0] mem_req_addr_r;
    logic                  mem_req_valid_r;
    logic                  resp_valid_r;
    logic [DATA_WIDTH-1:0] resp_data_r;

    function automatic ages_t lru_touch(input ages_t ages, input logic [1:0] idx);
        ages_t nxt;
        nxt = ages;
        for (int i = 0; i < CACHE_SIZE; i++) begin
            if (ages[i] < ages[idx]) begin
                nxt[i] = ages[i] + 2'd1;
            end else begin
                nxt[i] = ages[i];
            end
        end
        nxt[idx] = 2'd0;
        return nxt;
    endfunction

    function automatic logic [1:0] oldest_line(input ages_t ages);
        logic [1:0] line;
        line = 2'd0;
        for (int i = 0; i < CACHE_SIZE; i++) begin
            if (ages[i] == 2'd3) begin
                line = 2'(i);
            end else begin
                line = line;
            end
        end
        return line;
    endfunction

    function automatic logic [1:0] pick_victim(input logic [CACHE_SIZE-1:0] valid,
                                               input ages_t ages);
        logic [1:0] line;
        casez (valid)
            4'b???0: line = 2'd0;
            4'b??01: line = 2'd1;
            4'b?011: line = 2'd2;
            4'b0111: line = 2'd3;
            default: line = oldest_line(ages);
        endcase
        return line;
    endfunction

    // Controller FSM together with the tag, valid, data and age stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            valid_r         <= {CACHE_SIZE{1'b0}};
            age_r           <= {2'd3, 2'd2, 2'd1, 2'd0};
            victim_r        <= 2'd0;
            lookup_addr_r   <= {ADDR_WIDTH{1'b0}};
            mem_req_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_req_valid_r <= 1'b0;
            resp_valid_r    <= 1'b0;
            resp_data_r     <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < CACHE_SIZE; i++) begin
                tag_r[i]  <= {ADDR_WIDTH{1'b0}};
                data_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    resp_valid_r <= 1'b0;
                    if (bus.flush) begin
                        valid_r <= {CACHE_SIZE{1'b0}};
                        state_r <= IDLE;
                    end else if (bus.req_valid) begin
                        lookup_addr_r <= bus.req_addr;
                        state_r       <= LOOKUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOOKUP: begin
                    if (bus.hit) begin
                        resp_data_r  <= data_r[bus.hit_index];
                        age_r        <= lru_touch(age_r, bus.hit_index);
                        resp_valid_r <= 1'b1;
                        state_r      <= RESP;
                    end else begin
                        victim_r        <= pick_victim(valid_r, age_r);
                        mem_req_valid_r <= 1'b1;
                        mem_req_addr_r  <= lookup_addr_r;
                        state_r         <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        state_r         <= MISS_WAIT;
                    end else begin
                        state_r <= MISS_REQ;
                    end
                end
                MISS_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        tag_r[victim_r]   <= lookup_addr_r;
                        valid_r[victim_r] <= 1'b1;
                        data_r[victim_r]  <= bus.mem_resp_data;
                        resp_data_r       <= bus.mem_resp_data;
                        age_r             <= lru_touch(age_r, victim_r);
                        resp_valid_r      <= 1'b1;
                        state_r           <= RESP;
                    end else begin
                        state_r <= MISS_WAIT;
                    end
                end
                RESP: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    resp_valid_r    <= 1'b0;
                    mem_req_valid_r <= 1'b0;
                    state_r         <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = (state_r == IDLE) && !bus.flush;
    assign bus.lookup_addr   = lookup_addr_r;
    assign bus.resp_valid    = resp_valid_r;
    assign bus.resp_data     = resp_data_r;
    assign bus.mem_req_valid = mem_req_valid_r;
    assign bus.mem_req_addr  = mem_req_addr_r;
    assign bus.tag_out_0     = tag_r[0];
    assign bus.tag_out_1     = tag_r[1];
    assign bus.tag_out_2     = tag_r[2];
    assign bus.tag_out_3     = tag_r[3];
    assign bus.valid_0       = valid_r[0];
    assign bus.valid_1       = valid_r[1];
    assign bus.valid_2       = valid_r[2];
    assign bus.valid_3       = valid_r[3];
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed scenarios plus random reads, scoreboarded against
// a queue-based cache model (MRU-ordered line list) with a behavioural comparator and memory.
module tb_cache_refill_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cache_refill_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    cache_refill_ctrl #(.CACHE_SIZE(4), .ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] resp_q[$];
    logic [7:0] memreq_q[$];
    logic [7:0] m_tag[4];
    logic [7:0] m_data[4];
    bit         m_valid[4];
    int         lru_q[$];
    logic [7:0] mem_img[256];
    logic [7:0] last_lookup;
    logic [7:0] pool[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    logic [7:0] dut_tag[4];
    logic       dut_valid[4];
    logic [1:0] junk_idx = 2'd0;

    always_comb begin
        dut_tag[0]   = bus.tag_out_0;
        dut_tag[1]   = bus.tag_out_1;
        dut_tag[2]   = bus.tag_out_2;
        dut_tag[3]   = bus.tag_out_3;
        dut_valid[0] = bus.valid_0;
        dut_valid[1] = bus.valid_1;
        dut_valid[2] = bus.valid_2;
        dut_valid[3] = bus.valid_3;
    end

    // hit_index carries noise whenever there is no hit
    always @(posedge clk) junk_idx <= 2'($urandom);

    always_comb begin
        bus.hit       = 1'b0;
        bus.hit_index = junk_idx;
        for (int i = 0; i < 4; i++) begin
            if (dut_valid[i] && dut_tag[i] == bus.lookup_addr) begin
                bus.hit       = 1'b1;
                bus.hit_index = 2'(i);
            end
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_tag[i]   = 8'h00;
            m_data[i]  = 8'h00;
            m_valid[i] = 1'b0;
        end
        lru_q = '{0, 1, 2, 3};
        resp_q.delete();
        memreq_q.delete();
    endfunction

    function automatic void model_touch(input int line);
        for (int i = 0; i < lru_q.size(); i++) begin
            if (lru_q[i] == line) begin
                lru_q.delete(i);
                break;
            end
        end
        lru_q.push_front(line);
    endfunction

    function automatic bit model_access(input logic [7:0] addr);
        int line;
        bit h;
        h = 1'b0;
        line = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && m_tag[i] == addr) begin
                h = 1'b1;
                line = i;
            end
        end
        if (!h) begin
            line = -1;
            for (int i = 3; i >= 0; i--) begin
                if (!m_valid[i]) line = i;
            end
            if (line < 0) line = lru_q[lru_q.size()-1];
            m_tag[line]   = addr;
            m_valid[line] = 1'b1;
            m_data[line]  = mem_img[addr];
            memreq_q.push_back(addr);
        end
        resp_q.push_back(m_data[line]);
        model_touch(line);
        return h;
    endfunction

    // Scoreboard monitor: every response and every memory handshake pops an expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.resp_valid) begin
                if (resp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
                else chk("resp_data", 32'(bus.resp_data), 32'(resp_q.pop_front()));
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (memreq_q.size() == 0) chk("mem_req_unexpected", 32'd1, 32'd0);
                else chk("mem_req_addr", 32'(bus.mem_req_addr), 32'(memreq_q.pop_front()));
            end
        end
    end

    task automatic check_state();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tag_out_%0d", i), 32'(dut_tag[i]), 32'(m_tag[i]));
            chk($sformatf("valid_%0d", i), 32'(dut_valid[i]), 32'(m_valid[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_data"}, 32'(bus.resp_data), 32'd0);
        chk({tag, "_mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        chk({tag, "_mem_req_addr"}, 32'(bus.mem_req_addr), 32'd0);
        chk({tag, "_lookup_addr"}, 32'(bus.lookup_addr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_tag_%0d", tag, i), 32'(dut_tag[i]), 32'd0);
            chk($sformatf("%s_valid_%0d", tag, i), 32'(dut_valid[i]), 32'd0);
        end
    endtask

    task automatic do_read(input logic [7:0] addr, input int rdy_dly, input int resp_dly,
                           input bit early, input bit abort);
        bit exp_hit;
        bit acc;
        int k;
        exp_hit = model_access(addr);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 20) begin
            @(negedge clk);
            acc = bus.req_ready;
            k++;
            if (!acc) begin
                @(posedge clk); #1;
            end
        end
        chk("req_accept", 32'(acc), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 8'($urandom);
        @(negedge clk);
        k = 1;
        chk("lookup_addr", 32'(bus.lookup_addr), 32'(addr));
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
        last_lookup = addr;
        while (!bus.resp_valid && !bus.mem_req_valid && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("first_event_latency", 32'(k), 32'd2);
        if (exp_hit) begin
            chk("hit_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("hit_no_mem_req", 32'(bus.mem_req_valid), 32'd0);
        end else begin
            chk("miss_mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("miss_mem_req_addr", 32'(bus.mem_req_addr), 32'(addr));
            for (int d = 0; d < rdy_dly; d++) begin
                @(posedge clk); #1;
                bus.mem_resp_valid = early && (d == 0);
                bus.mem_resp_data  = ~mem_img[addr];
                @(negedge clk);
                chk("bp_mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
                chk("bp_mem_req_addr", 32'(bus.mem_req_addr), 32'(addr));
                chk("bp_no_resp", 32'(bus.resp_valid), 32'd0);
            end
            @(posedge clk); #1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_req_ready  = 1'b1;
            @(posedge clk); #1;
            bus.mem_req_ready  = 1'b0;
            if (abort) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                model_reset();
                check_reset_outputs("rst_mid");
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = 8'h77;
                @(posedge clk); #1;
                bus.mem_resp_valid = 1'b0;
                @(negedge clk);
                check_reset_outputs("late_resp");
                check_state();
                return;
            end
            for (int d = 0; d < resp_dly; d++) begin
                @(negedge clk);
                chk("wait_no_mem_req", 32'(bus.mem_req_valid), 32'd0);
                chk("wait_no_resp", 32'(bus.resp_valid), 32'd0);
                @(posedge clk); #1;
            end
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_img[addr];
            @(posedge clk); #1;
            bus.mem_resp_valid = 1'b0;
            bus.mem_resp_data  = 8'($urandom);
            @(negedge clk);
            chk("miss_resp_valid", 32'(bus.resp_valid), 32'd1);
        end
        @(negedge clk);
        chk("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
        chk("req_ready_after", 32'(bus.req_ready), 32'd1);
        check_state();
    endtask

    task automatic do_flush(input bit with_req);
        @(posedge clk); #1;
        bus.flush     = 1'b1;
        bus.req_valid = with_req;
        bus.req_addr  = 8'($urandom);
        #1;
        chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        @(negedge clk);
        chk("flush_req_not_taken", 32'(bus.req_ready), 32'd1);
        chk("flush_lookup_kept", 32'(bus.lookup_addr), 32'(last_lookup));
        check_state();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        last_lookup = 8'h00;
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.req_valid      = 1'b0;
        bus.req_addr       = 8'h00;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 8'h00;
        bus.flush          = 1'b0;
        for (int i = 0; i < 256; i++) mem_img[i] = 8'($urandom);
        mem_img[8'h3C] = 8'hA5;
        model_reset();
        last_lookup = 8'h00;
        apply_reset();

        // cold miss then hit on the same address
        do_read(8'h3C, 0, 3, 1'b0, 1'b0);
        chk("cold_tag0", 32'(dut_tag[0]), 32'h3C);
        do_read(8'h3C, 0, 0, 1'b0, 1'b0);

        // fill four lines, touch line 0, then evict the LRU line
        apply_reset();
        do_read(8'h10, 0, 0, 1'b0, 1'b0);
        do_read(8'h20, 1, 1, 1'b0, 1'b0);
        do_read(8'h30, 0, 2, 1'b0, 1'b0);
        do_read(8'h40, 2, 0, 1'b0, 1'b0);
        do_read(8'h10, 0, 0, 1'b0, 1'b0);
        do_read(8'h50, 0, 1, 1'b0, 1'b0);
        chk("evict_tag1", 32'(dut_tag[1]), 32'h50);
        do_read(8'h20, 0, 0, 1'b0, 1'b0);

        // memory backpressure with a stray early response
        do_read(8'h66, 5, 2, 1'b1, 1'b0);

        // flush with a pending request, then the next read misses
        do_flush(1'b1);
        do_read(8'h50, 0, 0, 1'b0, 1'b0);

        // reset while the refill is outstanding
        do_read(8'h77, 1, 0, 1'b0, 1'b1);

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_flush(1'($urandom_range(0, 1)));
            end else begin
                do_read(pool[$urandom_range(0, 5)], int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
            end
        end

        chk("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        chk("memreq_queue_drained", 32'(memreq_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
